// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Canonical RISC-V NOP: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_bundle_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Flags a fetch address that is misaligned or beyond the instruction memory.
module fetch_addr_check #(
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic [31:0] pc,
  output logic        addr_bad
);

  logic [31:0] word_idx;

  assign word_idx = {2'b00, pc[31:2]};
  assign addr_bad = (pc[1:0] != 2'b00) || (word_idx >= 32'(IMEM_DEPTH));

endmodule

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch with stall, redirect and optional address check.
// Define IF_ADDR_CHECK_EN to enable alignment/range faults on the fetch address.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  if_bundle_t   out_q, out_d;
  logic         if_valid_q, if_valid_d;
  logic         if_fault_q, if_fault_d;
  logic         addr_bad;
  logic         can_capture;

  if (IMEM_DEPTH == 0) begin : g_bad_depth
    $error("instruction_fetch: IMEM_DEPTH must be nonzero");
  end

`ifdef IF_ADDR_CHECK_EN
  fetch_addr_check #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_addr_check (
    .pc       (pc_q),
    .addr_bad (addr_bad)
  );
`else
  assign addr_bad = 1'b0;
`endif

  // 32-bit add wraps naturally from 32'hFFFF_FFFC to 0.
  assign pc_plus4    = pc_q + 32'd4;
  assign can_capture = !if_valid_q || if_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    out_d      = out_q;
    if_valid_d = if_valid_q;
    if_fault_d = if_fault_q;

    if (redirect_valid) begin
      // Redirect wins over stall; any transfer this cycle still completes
      // because the consumer sees if_valid=1 with if_ready=1 at this edge.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_fault_d = 1'b0;
      state_d    = RUN;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (can_capture) begin
            if (addr_bad) begin
              if_valid_d = 1'b0;
              if_fault_d = 1'b1;
              state_d    = FAULT;
            end else begin
              out_d      = '{instr: imem_data, pc: pc_q, pc_plus4: pc_plus4};
              if_valid_d = 1'b1;
              pc_d       = pc_plus4;
            end
          end
        end
        FAULT: begin
          if_valid_d = 1'b0;
          if_fault_d = 1'b1;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      out_q      <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
      if_valid_q <= 1'b0;
      if_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_q      <= out_d;
      if_valid_q <= if_valid_d;
      if_fault_q <= if_fault_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = out_q.instr;
  assign if_pc       = out_q.pc;
  assign if_pc_plus4 = out_q.pc_plus4;
  assign if_fault    = if_fault_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 256, the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to instruction memory, driven combinationally from the PC register.
REQ-006 SHALL have port imem_data, input, 32 bits: instruction word returned combinationally by memory for imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target, sampled when redirect_valid=1.
REQ-009 SHALL have port if_valid, output, 1 bit: if_instr, if_pc and if_pc_plus4 hold a valid fetched instruction.
REQ-010 SHALL have port if_ready, input, 1 bit: the decode stage accepts the output this cycle.
REQ-011 SHALL have port if_instr, output, 32 bits: registered instruction word.
REQ-012 SHALL have port if_pc, output, 32 bits: registered address of if_instr.
REQ-013 SHALL have port if_pc_plus4, output, 32 bits: registered if_pc+4.
REQ-014 SHALL have port if_fault, output, 1 bit: fetch address fault, sticky until a redirect.

Function
REQ-015 SHALL implement FSM states BOOT, RUN and FAULT.
REQ-016 BOOT SHALL last exactly one cycle with no capture, then move to RUN.
REQ-017 A transfer SHALL occur on a cycle where if_valid=1 and if_ready=1.
REQ-018 In RUN, when if_valid=0 or if_ready=1, SHALL load if_instr<=imem_data, if_pc<=pc and if_pc_plus4<=pc+4, set if_valid<=1 and advance pc<=pc+4.
REQ-019 When if_valid=1 and if_ready=0 (stall), pc and all outputs SHALL hold unchanged.
REQ-020 redirect_valid SHALL take priority over stall and capture in every state: pc<=redirect_pc, if_valid<=0, if_fault<=0, state<=RUN.
REQ-021 Redirect-to-valid latency SHALL be 2 cycles: redirect in cycle N, target visible with if_valid=1 in cycle N+2, giving exactly one bubble.
REQ-022 A redirect in the same cycle as a transfer SHALL still complete the transfer and discard the fetch in flight.
REQ-023 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-024 In FAULT, if_valid SHALL be 0, if_fault SHALL be 1 and pc SHALL hold until a redirect.

Reset
REQ-025 While rst=1, SHALL set pc=RESET_PC, state=BOOT, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, if_pc_plus4=0 and if_fault=0.
REQ-026 rst SHALL override redirect_valid and if_ready, including during a stall or while in FAULT.

Configuration
REQ-027 With macro IF_ADDR_CHECK_EN defined: in RUN, if pc[1:0]!=0 or (pc>>2)>=IMEM_DEPTH, SHALL perform no capture, set if_valid<=0 and if_fault<=1, and enter FAULT.
REQ-028 With IF_ADDR_CHECK_EN undefined: no address checks; FAULT is unreachable; if_fault is tied to 0; out-of-range addresses are passed to memory unchanged.

Structure
REQ-029 Package fetch_pkg SHALL hold the fetch_state_t enum (BOOT, RUN, FAULT), the NOP constant 32'h0000_0013 and the default RESET_PC.
REQ-030 Sub-module fetch_addr_check (combinational: pc, IMEM_DEPTH -> addr_bad) SHALL be instantiated only under IF_ADDR_CHECK_EN.

Verification
REQ-031 Reset with RESET_PC=0 and if_ready=1 -> cycle 1 if_valid=0; from cycle 2 if_pc is 0x0, then 0x4, then 0x8; if_instr equals memory words 0, 1, 2.
REQ-032 if_ready=0 for 3 cycles while if_pc=0x8 -> if_pc, if_instr and imem_addr=0xC stay stable; on release, next if_pc is 0xC.
REQ-033 Redirect to 0x40 while if_pc=0x10 -> one bubble (if_valid=0), then if_pc=0x40 and if_pc_plus4=0x44.
REQ-034 IF_ADDR_CHECK_EN defined, redirect to 0x402 or 0x400 (IMEM_DEPTH=256) -> if_fault=1 and if_valid=0 held; a later redirect to 0x0 clears the fault and fetch resumes.
REQ-035 rst asserted during a stall with if_valid=1 -> next cycle if_valid=0, pc=RESET_PC, if_instr=0x00000013.
REQ-036 RESET_PC=32'hFFFF_FFFC, IF_ADDR_CHECK_EN undefined -> if_pc sequence FFFF_FFFC, 0000_0000, with if_pc_plus4 of FFFF_FFFC equal to 0.
